// File: rtl/eda_neighbor_fifo_bank.sv
// Neighbor-address queue bank: expands a center pixel into up to 8 in-range 3x3 neighbors, one FIFO per direction.
// Latency: push visible on the read side 1 cycle later; read_en -> data_out is combinational.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flags sticky overflow.
module eda_neighbor_fifo_bank #(
    parameter int WINDOW_WIDTH = 9,
    parameter int I_WIDTH      = 8,
    parameter int J_WIDTH      = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push_valid,
    input  logic [WINDOW_WIDTH-2:0] push_positions,
    input  logic [ADDR_WIDTH-1:0]   center_addr,
    input  logic [WINDOW_WIDTH-2:0] read_en,
    output logic [WINDOW_WIDTH-2:0] fifo_empty,
    output logic [WINDOW_WIDTH-2:0] fifo_full,
    output logic [ADDR_WIDTH-1:0]   data_out,
    output logic                    pending,
    output logic                    overflow
);
    localparam int N     = WINDOW_WIDTH - 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    logic [ADDR_WIDTH-1:0] mem [N][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [N];
    logic [PTR_W-1:0]      rd_ptr [N];
    logic [PTR_W:0]        cnt    [N];

    logic [I_WIDTH-1:0]    row, row_m1, row_p1;
    logic [J_WIDTH-1:0]    col, col_m1, col_p1;
    logic                  row_lo_ok, row_hi_ok, col_lo_ok, col_hi_ok;
    logic [ADDR_WIDTH-1:0] nb_addr [N];
    logic [N-1:0]          nb_ok;
    logic [N-1:0]          push_req, do_push, do_pop;
    logic                  drop;

    assign row       = center_addr[ADDR_WIDTH-1:J_WIDTH];
    assign col       = center_addr[J_WIDTH-1:0];
    assign row_m1    = row - I_WIDTH'(1);
    assign row_p1    = row + I_WIDTH'(1);
    assign col_m1    = col - J_WIDTH'(1);
    assign col_p1    = col + J_WIDTH'(1);
    assign row_lo_ok = (row != '0);
    assign row_hi_ok = (row != '1);
    assign col_lo_ok = (col != '0);
    assign col_hi_ok = (col != '1);

    // Direction k: rows {0,1,2}=up, {3,4}=same, {5,6,7}=down; cols {0,3,5}=left, {1,6}=same, {2,4,7}=right.
    always_comb begin
        logic [I_WIDTH-1:0] r;
        logic [J_WIDTH-1:0] c;
        logic               rok, cok;
        for (int k = 0; k < N; k++) begin
            case (k)
                0, 1, 2: begin r = row_m1; rok = row_lo_ok; end
                3, 4:    begin r = row;    rok = 1'b1;      end
                default: begin r = row_p1; rok = row_hi_ok; end
            endcase
            case (k)
                0, 3, 5: begin c = col_m1; cok = col_lo_ok; end
                1, 6:    begin c = col;    cok = 1'b1;      end
                default: begin c = col_p1; cok = col_hi_ok; end
            endcase
            nb_addr[k] = {r, c};
            nb_ok[k]   = rok & cok;
        end
    end

    always_comb begin
        drop = 1'b0;
        for (int k = 0; k < N; k++) begin
            push_req[k]   = push_valid & push_positions[k] & nb_ok[k];
            fifo_empty[k] = (cnt[k] == '0);
            fifo_full[k]  = (cnt[k] == FULL_CNT);
            do_pop[k]     = read_en[k] & ~fifo_empty[k];
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            do_push[k]    = push_req[k] & (~fifo_full[k] | do_pop[k]);
            if (push_req[k] & fifo_full[k] & ~do_pop[k])
                drop = 1'b1;
        end
    end

    assign pending = ~&fifo_empty;

    // Highest set read_en bit wins when the select is not one-hot.
    always_comb begin
        data_out = '0;
        for (int k = 0; k < N; k++) begin
            if (read_en[k])
                data_out = fifo_empty[k] ? '0 : mem[k][rd_ptr[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow <= 1'b0;
            for (int k = 0; k < N; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            if (drop)
                overflow <= 1'b1;
            for (int k = 0; k < N; k++) begin
                if (do_push[k])
                    wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                if (do_pop[k])
                    rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
                case ({do_push[k], do_pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + CNT_ONE;
                    2'b01:   cnt[k] <= cnt[k] - CNT_ONE;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    // Storage is never flushed; pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (do_push[k] && !reset && !clear)
                mem[k][wr_ptr[k]] <= nb_addr[k];
        end
    end
endmodule
